// File: rtl/synchronous_packet_fifo.sv
// Single-clock packet FIFO with binary wrap-bit pointers, occupancy flags and optional FWFT output.
// Define SYNCHRONOUS_PACKET_FIFO_STORE_AND_FORWARD_EN to expose only whole packets and drop oversize ones.
module synchronous_packet_fifo #(
    parameter int DATA_WIDTH              = 16,
    parameter int DATA_DEPTH              = 1024,
    parameter int FIRST_WORD_FALL_THROUGH = 0,
    parameter int ALMOST_FULL_THRESHOLD   = DATA_DEPTH - 4,
    parameter int ALMOST_EMPTY_THRESHOLD  = 4,
    localparam int ADDRESS_WIDTH          = $clog2(DATA_DEPTH)
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic                    i_write_enable,
    input  logic [DATA_WIDTH-1:0]   i_write_data,
    input  logic                    i_write_last,
    input  logic                    i_read_enable,
    output logic [DATA_WIDTH-1:0]   o_read_data,
    output logic                    o_read_last,
    output logic                    o_read_data_valid,
    output logic [ADDRESS_WIDTH:0]  o_word_count,
    output logic                    o_full,
    output logic                    o_empty,
    output logic                    o_almost_full,
    output logic                    o_almost_empty,
    output logic                    o_write_overflow,
    output logic                    o_read_underflow
);

    localparam logic [ADDRESS_WIDTH:0] DEPTH_COUNT = (ADDRESS_WIDTH + 1)'(DATA_DEPTH);
    localparam logic [ADDRESS_WIDTH:0] AF_LEVEL    = (ADDRESS_WIDTH + 1)'(ALMOST_FULL_THRESHOLD);
    localparam logic [ADDRESS_WIDTH:0] AE_LEVEL    = (ADDRESS_WIDTH + 1)'(ALMOST_EMPTY_THRESHOLD);

    logic [DATA_WIDTH:0]    r_memory [DATA_DEPTH];
    logic [ADDRESS_WIDTH:0] r_write_pointer;
    logic [ADDRESS_WIDTH:0] r_read_pointer;
    logic [ADDRESS_WIDTH:0] w_commit_pointer;
    logic                   w_full;
    logic                   w_memory_empty;
    logic                   w_write_accept;
    logic                   w_write_reject;
    logic                   w_rewind;
    logic                   w_pop_memory;
    logic                   w_underflow_request;
    logic                   w_valid_next;
    logic                   r_read_data_valid;
    logic [DATA_WIDTH-1:0]  r_read_data;
    logic                   r_read_last;
    logic                   r_write_overflow;
    logic                   r_read_underflow;

    assign o_word_count   = r_write_pointer - r_read_pointer;
    assign w_full         = (o_word_count == DEPTH_COUNT);
    assign w_memory_empty = (r_read_pointer == w_commit_pointer);
    assign o_full         = w_full;
    assign o_almost_full  = (o_word_count >= AF_LEVEL);
    assign o_almost_empty = (o_word_count <= AE_LEVEL);

`ifdef SYNCHRONOUS_PACKET_FIFO_STORE_AND_FORWARD_EN
    localparam logic STATE_ACCEPT  = 1'b0;
    localparam logic STATE_DISCARD = 1'b1;

    logic                   r_state;
    logic [ADDRESS_WIDTH:0] r_commit_pointer;

    assign w_commit_pointer = r_commit_pointer;
    assign w_write_accept   = i_write_enable && !w_full && (r_state == STATE_ACCEPT);
    assign w_write_reject   = i_write_enable && w_full && (r_state == STATE_ACCEPT);
    assign w_rewind         = w_write_reject;

    // A rejected word that is not the packet tail leaves the rest of that packet to be dropped silently.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state          <= STATE_ACCEPT;
            r_commit_pointer <= '0;
        end else begin
            if (r_state == STATE_DISCARD) begin
                if (i_write_enable && i_write_last) r_state <= STATE_ACCEPT;
            end else if (w_write_reject && !i_write_last) begin
                r_state <= STATE_DISCARD;
            end
            if (w_write_accept && i_write_last) r_commit_pointer <= r_write_pointer + 1'b1;
        end
    end
`else
    assign w_commit_pointer = r_write_pointer;
    assign w_write_accept   = i_write_enable && !w_full;
    assign w_write_reject   = i_write_enable && w_full;
    assign w_rewind         = 1'b0;
`endif

    generate
        if (FIRST_WORD_FALL_THROUGH != 0) begin : g_fwft
            // The output register refills whenever it is vacant or being acknowledged.
            assign w_pop_memory        = (!r_read_data_valid || i_read_enable) && !w_memory_empty;
            assign w_underflow_request = i_read_enable && !r_read_data_valid;
            assign w_valid_next        = w_pop_memory ? 1'b1 : (i_read_enable ? 1'b0 : r_read_data_valid);
            assign o_empty             = !r_read_data_valid;
        end else begin : g_standard
            assign w_pop_memory        = i_read_enable && !w_memory_empty;
            assign w_underflow_request = i_read_enable && w_memory_empty;
            assign w_valid_next        = w_pop_memory;
            assign o_empty             = w_memory_empty;
        end
    endgenerate

    always_ff @(posedge clock) begin
        if (w_write_accept) r_memory[r_write_pointer[ADDRESS_WIDTH-1:0]] <= {i_write_last, i_write_data};
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_write_pointer   <= '0;
            r_read_pointer    <= '0;
            r_read_data       <= '0;
            r_read_last       <= 1'b0;
            r_read_data_valid <= 1'b0;
            r_write_overflow  <= 1'b0;
            r_read_underflow  <= 1'b0;
        end else begin
            if (w_write_accept) begin
                r_write_pointer <= r_write_pointer + 1'b1;
            end else if (w_rewind) begin
                r_write_pointer <= w_commit_pointer;
            end
            if (w_pop_memory) begin
                r_read_pointer <= r_read_pointer + 1'b1;
                {r_read_last, r_read_data} <= r_memory[r_read_pointer[ADDRESS_WIDTH-1:0]];
            end
            r_read_data_valid <= w_valid_next;
            r_write_overflow  <= w_write_reject;
            r_read_underflow  <= w_underflow_request;
        end
    end

    assign o_read_data       = r_read_data;
    assign o_read_last       = r_read_last;
    assign o_read_data_valid = r_read_data_valid;
    assign o_write_overflow  = r_write_overflow;
    assign o_read_underflow  = r_read_underflow;

endmodule
